// File: rtl/pll_seq_pkg.sv
// Shared constants and helpers for the PLL reset sequencer and its lock synchroniser.
package pll_seq_pkg;

    localparam int unsigned RELOCK_W = 8;
    localparam int unsigned STATE_W  = 3;

    localparam logic [2:0] S_PLLRST    = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_FILTER    = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for an asynchronous level, synchronous active-high reset to 0.
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Resolve metastability over two refclk stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: pulses the PLL reset, filters lock, releases channel resets in a
// staggered order, and retries on timeout or lock loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_CLK        = 5,
    parameter int unsigned LOCK_FILTER    = 1024,
    parameter int unsigned STAGGER        = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned PLL_RST_CYCLES = 32
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic [NUM_CLK-1:0]  chan_rst,
    output logic                all_ready,
    output logic [RELOCK_W-1:0] relock_cnt,
    output logic                timeout_err,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned REL_SPAN = NUM_CLK * STAGGER;
    localparam int unsigned MAX_A    = (LOCK_TIMEOUT > LOCK_FILTER) ? LOCK_TIMEOUT : LOCK_FILTER;
    localparam int unsigned MAX_B    = (REL_SPAN > PLL_RST_CYCLES) ? REL_SPAN : PLL_RST_CYCLES;
    localparam int unsigned MAX_ALL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W    = clog2(MAX_ALL + 1);

    logic                lk;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    tcnt;
    logic [CNT_W-1:0]    tcnt_nxt;
    logic [STATE_W-1:0]  state_nxt;
    logic [NUM_CLK-1:0]  chan_nxt;
    logic                tmo_set;
    logic                relock_inc;

    pll_lock_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // Next-state, counter and next-output logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tcnt_nxt   = tcnt;
        tmo_set    = 1'b0;
        relock_inc = 1'b0;
        chan_nxt   = '1;

        case (state)
            S_PLLRST: begin
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                    tcnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                tcnt_nxt = tcnt + 1'b1;
                if (tcnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                    tmo_set   = 1'b1;
                end else if (lk) begin
                    state_nxt = S_FILTER;
                    cnt_nxt   = '0;
                end
            end
            S_FILTER: begin
                tcnt_nxt = tcnt + 1'b1;
                if (tcnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                    tmo_set   = 1'b1;
                end else if (!lk) begin
                    // Glitch restarts filtering but keeps the timeout budget running.
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
                    state_nxt = S_RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lk) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                    tcnt_nxt  = '0;
                end else if (cnt == CNT_W'((NUM_CLK - 1) * STAGGER)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_nxt  = S_WAIT_LOCK;
                    cnt_nxt    = '0;
                    tcnt_nxt   = '0;
                    relock_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = S_PLLRST;
                cnt_nxt   = '0;
                tcnt_nxt  = '0;
            end
        endcase

        // Channel k clears on the cycle whose counter value equals k*STAGGER; released stay released.
        if (state_nxt == S_RUN) begin
            chan_nxt = '0;
        end else if (state_nxt == S_RELEASE) begin
            chan_nxt = (state == S_RELEASE) ? chan_rst : '1;
            for (int unsigned k = 0; k < NUM_CLK; k++) begin
                if (cnt_nxt == CNT_W'(k * STAGGER)) begin
                    chan_nxt[k] = 1'b0;
                end
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_PLLRST;
            cnt         <= '0;
            tcnt        <= '0;
            pll_rst     <= 1'b1;
            chan_rst    <= '1;
            all_ready   <= 1'b0;
            relock_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tcnt      <= tcnt_nxt;
            pll_rst   <= (state_nxt == S_PLLRST);
            chan_rst  <= chan_nxt;
            all_ready <= (state_nxt == S_RUN);
            if (relock_inc && (relock_cnt != '1)) begin
                relock_cnt <= relock_cnt + 1'b1;
            end
            if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] chan_rst;
    logic       all_ready;
    logic [7:0] relock_cnt;
    logic       timeout_err;
    logic [2:0] state;

    int n_checks;
    int n_errors;
    int cyc;

    pll_reset_sequencer #(
        .NUM_CLK        (3),
        .LOCK_FILTER    (8),
        .STAGGER        (4),
        .LOCK_TIMEOUT   (64),
        .PLL_RST_CYCLES (4)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .chan_rst    (chan_rst),
        .all_ready   (all_ready),
        .relock_cnt  (relock_cnt),
        .timeout_err (timeout_err),
        .state       (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Single comparison point: count and report mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    // Hold rst for three edges; cycle 0 is the sample right after the last reset edge.
    task automatic do_reset(input logic lv);
        rst        = 1'b1;
        pll_locked = lv;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_at(input int n, input string tag, input logic [2:0] st,
                             input logic [2:0] ch, input logic pr, input logic rdy);
        tick_to(n);
        chk($sformatf("%s_c%0d_state", tag, n), 32'(state), 32'(st));
        chk($sformatf("%s_c%0d_chan", tag, n), 32'(chan_rst), 32'(ch));
        chk($sformatf("%s_c%0d_pllrst", tag, n), 32'(pll_rst), 32'(pr));
        chk($sformatf("%s_c%0d_ready", tag, n), 32'(all_ready), 32'(rdy));
    endtask

    int n;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Reset, PLL reset width and timeout retry with no lock at all.
        do_reset(1'b0);
        chk("rst_relock", 32'(relock_cnt), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 4; i++) expect_at(i, "plr", 3'd0, 3'b111, 1'b1, 1'b0);
        expect_at(4, "plr", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(67, "tmo", 3'd1, 3'b111, 1'b0, 1'b0);
        chk("tmo_c67_err", 32'(timeout_err), 32'd0);
        expect_at(68, "tmo", 3'd0, 3'b111, 1'b1, 1'b0);
        chk("tmo_c68_err", 32'(timeout_err), 32'd1);
        expect_at(71, "tmo", 3'd0, 3'b111, 1'b1, 1'b0);
        expect_at(72, "tmo", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(135, "tmo", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(136, "tmo", 3'd0, 3'b111, 1'b1, 1'b0);
        expect_at(140, "tmo", 3'd1, 3'b111, 1'b0, 1'b0);
        chk("tmo_c140_err", 32'(timeout_err), 32'd1);

        // Clean lock: staggered release then RUN.
        do_reset(1'b1);
        expect_at(4,  "up", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(5,  "up", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(12, "up", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(13, "up", 3'd3, 3'b110, 1'b0, 1'b0);
        expect_at(16, "up", 3'd3, 3'b110, 1'b0, 1'b0);
        expect_at(17, "up", 3'd3, 3'b100, 1'b0, 1'b0);
        expect_at(20, "up", 3'd3, 3'b100, 1'b0, 1'b0);
        expect_at(21, "up", 3'd3, 3'b000, 1'b0, 1'b0);
        expect_at(22, "up", 3'd4, 3'b000, 1'b0, 1'b1);
        chk("up_relock", 32'(relock_cnt), 32'd0);
        chk("up_tmo", 32'(timeout_err), 32'd0);

        // One-cycle lock glitch while filtering restarts the filter.
        do_reset(1'b1);
        tick_to(8);
        pll_locked = 1'b0;
        tick_to(9);
        pll_locked = 1'b1;
        expect_at(10, "glt", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(11, "glt", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(12, "glt", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(19, "glt", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(20, "glt", 3'd3, 3'b110, 1'b0, 1'b0);

        // Three lock losses in RUN, then a timeout, then rst mid-release.
        do_reset(1'b1);
        expect_at(22, "rl", 3'd4, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n = 22 + 22 * i;
            pll_locked = 1'b0;
            expect_at(n + 2, "rl", 3'd4, 3'b000, 1'b0, 1'b1);
            pll_locked = 1'b1;
            expect_at(n + 3, "rl", 3'd1, 3'b111, 1'b0, 1'b0);
            chk($sformatf("rl_c%0d_cnt", n + 3), 32'(relock_cnt), 32'(i + 1));
            expect_at(n + 22, "rl", 3'd4, 3'b000, 1'b0, 1'b1);
        end
        chk("rl_final_cnt", 32'(relock_cnt), 32'd3);
        pll_locked = 1'b0;
        expect_at(91, "rl", 3'd1, 3'b111, 1'b0, 1'b0);
        chk("rl_c91_cnt", 32'(relock_cnt), 32'd4);
        tick_to(150);
        pll_locked = 1'b1;
        expect_at(152, "ft", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(153, "ft", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(154, "ft", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(155, "ft", 3'd0, 3'b111, 1'b1, 1'b0);
        chk("ft_c155_err", 32'(timeout_err), 32'd1);
        expect_at(159, "ft", 3'd1, 3'b111, 1'b0, 1'b0);
        expect_at(160, "ft", 3'd2, 3'b111, 1'b0, 1'b0);
        expect_at(168, "ft", 3'd3, 3'b110, 1'b0, 1'b0);
        chk("ft_c168_cnt", 32'(relock_cnt), 32'd4);
        chk("ft_c168_err", 32'(timeout_err), 32'd1);
        rst = 1'b1;
        expect_at(169, "mrst", 3'd0, 3'b111, 1'b1, 1'b0);
        chk("mrst_relock", 32'(relock_cnt), 32'd0);
        chk("mrst_tmo", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
